// File: rtl/lsu_mem_master.sv
// lsu_mem_master: core-side load/store initiator for a word-addressed,
// byte-masked data memory with combinational read data.
//
// One request is taken at a time. Stores are lane-shifted and masked, and
// loads are extracted and then sign- or zero-extended. Every accepted request
// produces exactly one response pulse.
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   - misaligned H/W accesses are performed. An access that crosses a
//               word boundary uses a second beat (ACC1).
//   undefined - any misaligned access returns an error response and issues no
//               memory beat. ACC1 and the second-word path are not built.
//
// Ports
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_req_valid/o_req_ready  request handshake (ready only while idle)
//   i_req_we, i_funct3    store flag, RV32I size/sign code
//   i_addr, i_wdata       byte address, right-justified store data
//   o_rsp_valid/o_rsp_err one-cycle response pulse and error flag
//   o_rdata               extended load data (0 for stores and errors)
//   o_mem_addr/wdata/bmask/wren  memory beat, valid only in ACC states
//   i_mem_rdata           combinational read word for o_mem_addr
module lsu_mem_master #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [2:0]        i_funct3,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic              o_rsp_valid,
   output logic              o_rsp_err,
   output logic [31:0]       o_rdata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic [3:0]        o_mem_bmask,
   output logic              o_mem_wren,
   input  logic [31:0]       i_mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC0 = 2'd1,
      ST_RESP = 2'd2
`ifdef LSU_MISALIGN_SPLIT_EN
      , ST_ACC1 = 2'd3
`endif
   } state_t;

   // Byte-lane footprint of an access size, before lane shifting.
   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
   endfunction

   // Extend the right-justified load value according to funct3.
   function automatic logic [31:0] load_ext(input logic [31:0] v, input logic [2:0] f3);
      case (f3)
         3'b000:  load_ext = {{24{v[7]}}, v[7:0]};
         3'b001:  load_ext = {{16{v[15]}}, v[15:0]};
         3'b100:  load_ext = {24'b0, v[7:0]};
         3'b101:  load_ext = {16'b0, v[15:0]};
         default: load_ext = v;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic                req_we_q;
   logic [2:0]          req_f3_q;
   logic [1:0]          req_off_q;
   logic [4:0]          req_sh;

   logic                ready_d, rsp_valid_d, rsp_err_d, wren_d;
   logic [31:0]         rdata_d, mem_wdata_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic [3:0]          bmask_d;

   logic [1:0]          in_off;
   logic                in_is_h, in_is_w, in_illegal, in_err;
   logic [ADDR_W-1:0]   in_word;
   logic [31:0]         lo_data;
   logic [3:0]          lo_mask;
   logic [31:0]         rd_shift, rsp_data;

`ifdef LSU_MISALIGN_SPLIT_EN
   logic [ADDR_W-1:0]   req_word_q;
   logic [31:0]         req_wdata_q;
   logic                req_cross_q;
   logic [31:0]         word0_q;
   logic                in_cross;
   logic [31:0]         hi_data;
   logic [3:0]          hi_mask;
   logic [63:0]         rd_wide;
`else
   logic                in_mis;
`endif

   // Classification of the incoming request.
   assign in_off     = i_addr[1:0];
   assign in_is_h    = (i_funct3[1:0] == 2'b01);
   assign in_is_w    = (i_funct3[1:0] == 2'b10);
   assign in_illegal = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) || (i_req_we && i_funct3[2]);
`ifdef LSU_MISALIGN_SPLIT_EN
   assign in_cross   = (in_is_h && (in_off == 2'd3)) || (in_is_w && (in_off != 2'd0));
   assign in_err     = in_illegal;
`else
   assign in_mis     = (in_is_h && in_off[0]) || (in_is_w && (in_off != 2'd0));
   assign in_err     = in_illegal || in_mis;
`endif

   // First beat is built straight from the request so it is ready in ACC0.
   assign in_word = {i_addr[ADDR_W-1:2], 2'b00};
   assign lo_data = i_wdata << {in_off, 3'b000};
   assign lo_mask = size_mask(i_funct3[1:0]) << in_off;

   assign req_sh  = {req_off_q, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
   // Second beat carries the bytes shifted past the first word.
   assign hi_data  = 32'(({32'b0, req_wdata_q} << req_sh) >> 32);
   assign hi_mask  = 4'((8'(size_mask(req_f3_q[1:0])) << req_off_q) >> 4);
   assign rd_wide  = (state_q == ST_ACC1) ? {i_mem_rdata, word0_q} : {32'b0, i_mem_rdata};
   assign rd_shift = 32'(rd_wide >> req_sh);
`else
   assign rd_shift = i_mem_rdata >> req_sh;
`endif
   assign rsp_data = req_we_q ? 32'b0 : load_ext(rd_shift, req_f3_q);

   // State, request capture and registered outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_IDLE;
         o_req_ready <= 1'b1;
         o_rsp_valid <= 1'b0;
         o_rsp_err   <= 1'b0;
         o_rdata     <= '0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_bmask <= '0;
         o_mem_wren  <= 1'b0;
         req_we_q    <= 1'b0;
         req_f3_q    <= '0;
         req_off_q   <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
         req_word_q  <= '0;
         req_wdata_q <= '0;
         req_cross_q <= 1'b0;
         word0_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         o_req_ready <= ready_d;
         o_rsp_valid <= rsp_valid_d;
         o_rsp_err   <= rsp_err_d;
         o_rdata     <= rdata_d;
         o_mem_addr  <= mem_addr_d;
         o_mem_wdata <= mem_wdata_d;
         o_mem_bmask <= bmask_d;
         o_mem_wren  <= wren_d;
         if ((state_q == ST_IDLE) && i_req_valid && o_req_ready) begin
            req_we_q    <= i_req_we;
            req_f3_q    <= i_funct3;
            req_off_q   <= in_off;
`ifdef LSU_MISALIGN_SPLIT_EN
            req_word_q  <= in_word;
            req_wdata_q <= i_wdata;
            req_cross_q <= in_cross;
`endif
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         if (state_q == ST_ACC0) begin
            word0_q <= i_mem_rdata;
         end
`endif
      end
   end

   // Next state and next registered outputs.
   always_comb begin
      state_d     = state_q;
      ready_d     = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rdata_d     = '0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      bmask_d     = '0;
      wren_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            if (i_req_valid && o_req_ready) begin
               ready_d = 1'b0;
               if (in_err) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d    = ST_ACC0;
                  mem_addr_d = in_word;
                  if (i_req_we) begin
                     mem_wdata_d = lo_data;
                     bmask_d     = lo_mask;
                     wren_d      = |lo_mask;
                  end
               end
            end
         end
         ST_ACC0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (req_cross_q) begin
               state_d    = ST_ACC1;
               mem_addr_d = req_word_q + ADDR_W'(4);
               if (req_we_q) begin
                  mem_wdata_d = hi_data;
                  bmask_d     = hi_mask;
                  wren_d      = |hi_mask;
               end
            end else
`endif
            begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rdata_d     = rsp_data;
            end
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         ST_ACC1: begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rdata_d     = rsp_data;
         end
`endif
         ST_RESP: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-level reference model, per-cycle compare,
// and hand-computed literal checks.
module tb_lsu_mem_master;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_req_valid, o_req_ready, i_req_we;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr, i_wdata;
   logic        o_rsp_valid, o_rsp_err;
   logic [31:0] o_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata;
   logic [3:0]  o_mem_bmask;
   logic        o_mem_wren;

   lsu_mem_master #(.ADDR_W(32)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_we(i_req_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_rsp_valid(o_rsp_valid), .o_rsp_err(o_rsp_err), .o_rdata(o_rdata),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
      .o_mem_wren(o_mem_wren), .i_mem_rdata(i_mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic        ready;
      logic        rsp_valid;
      logic        rsp_err;
      logic [31:0] rdata;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [3:0]  bmask;
      logic        wren;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   int          errors = 0, checks = 0;
   bit          chk_en = 1'b0;
   bit          mem_init = 1'b1;
   logic [31:0] bmem [64];
   logic [7:0]  ref_b [256];

   int          cyc = 0, acc_cyc = 0, lat = 0, rsp_cnt = 0, wb_n = 0;
   logic [31:0] last_rdata;
   logic        last_err;
   logic [31:0] wb_addr [2];
   logic [31:0] wb_data [2];
   logic [3:0]  wb_mask [2];

   function automatic logic [7:0] init_byte(input logic [7:0] a);
      case (a)
         8'h20:   return 8'hFF;
         8'h21:   return 8'h7F;
         8'h22:   return 8'h01;
         8'h23:   return 8'h80;
         default: return a ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [31:0] init_word(input int w);
      return {init_byte(8'(4*w+3)), init_byte(8'(4*w+2)), init_byte(8'(4*w+1)), init_byte(8'(4*w))};
   endfunction

   function automatic exp_t idle_e();
      exp_t e;
      e = '0;
      e.ready = 1'b1;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   // Memory seen by the DUT: combinational read, masked byte write on the edge.
   assign i_mem_rdata = bmem[o_mem_addr[7:2]];
   always @(posedge i_clk) begin
      if (mem_init) begin
         for (int w = 0; w < 64; w++) bmem[w] <= init_word(w);
      end else if (o_mem_wren) begin
         for (int k = 0; k < 4; k++)
            if (o_mem_bmask[k]) bmem[o_mem_addr[7:2]][8*k +: 8] <= o_mem_wdata[8*k +: 8];
      end
   end

   // Single compare process: logs activity and checks every cycle against the model.
   always @(negedge i_clk) begin
      cyc++;
      if (i_req_valid && o_req_ready) acc_cyc = cyc;
      if (o_rsp_valid) begin
         lat        = cyc - acc_cyc;
         last_rdata = o_rdata;
         last_err   = o_rsp_err;
         rsp_cnt++;
      end
      if (o_mem_wren) begin
         if (wb_n < 2) begin
            wb_addr[wb_n] = o_mem_addr;
            wb_data[wb_n] = o_mem_wdata;
            wb_mask[wb_n] = o_mem_bmask;
         end
         wb_n++;
      end
      if (chk_en) begin
         if (exp_q.size() != 0) cur = exp_q.pop_front();
         else cur = idle_e();
         chk($sformatf("c%0d_ready", cyc),  32'(o_req_ready), 32'(cur.ready));
         chk($sformatf("c%0d_rspv", cyc),   32'(o_rsp_valid), 32'(cur.rsp_valid));
         chk($sformatf("c%0d_rsperr", cyc), 32'(o_rsp_err),   32'(cur.rsp_err));
         chk($sformatf("c%0d_rdata", cyc),  o_rdata,          cur.rdata);
         chk($sformatf("c%0d_maddr", cyc),  o_mem_addr,       cur.maddr);
         chk($sformatf("c%0d_mwdata", cyc), o_mem_wdata,      cur.mwdata);
         chk($sformatf("c%0d_bmask", cyc),  32'(o_mem_bmask), 32'(cur.bmask));
         chk($sformatf("c%0d_wren", cyc),   32'(o_mem_wren),  32'(cur.wren));
      end
   end

   // Model a request from byte-level rules, queue its per-cycle outputs, drive it.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      int          n, nbeat;
      logic [1:0]  off;
      logic        illegal, err;
      logic [63:0] wide;
      logic [31:0] base, val, a;
      logic [3:0]  m;
      exp_t        e;
      n       = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
      off     = addr[1:0];
      illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
`ifdef LSU_MISALIGN_SPLIT_EN
      err   = illegal;
      nbeat = (int'(off) + n > 4) ? 2 : 1;
`else
      err   = illegal || ((int'(off) % n) != 0);
      nbeat = 1;
`endif
      wb_n = 0;
      exp_q.push_back(idle_e());
      if (err) begin
         e = '0; e.rsp_valid = 1'b1; e.rsp_err = 1'b1;
         exp_q.push_back(e);
      end else begin
         wide = {32'b0, wd} << (8 * off);
         for (int b = 0; b < nbeat; b++) begin
            e       = '0;
            base    = {addr[31:2], 2'b00} + 32'(4 * b);
            e.maddr = base;
            m       = '0;
            for (int i = 0; i < n; i++) begin
               a = addr + 32'(i);
               if ({a[31:2], 2'b00} == base) m[a[1:0]] = 1'b1;
            end
            if (we) begin
               e.bmask  = m;
               e.mwdata = (b == 0) ? wide[31:0] : wide[63:32];
               e.wren   = 1'b1;
            end
            exp_q.push_back(e);
         end
         e = '0; e.rsp_valid = 1'b1;
         if (!we) begin
            val = '0;
            for (int i = 0; i < n; i++) val[8*i +: 8] = ref_b[8'(addr + 32'(i))];
            if (!f3[2] && n == 1) val = {{24{val[7]}}, val[7:0]};
            else if (!f3[2] && n == 2) val = {{16{val[15]}}, val[15:0]};
            e.rdata = val;
         end
         exp_q.push_back(e);
      end
      i_req_valid = 1'b1; i_req_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
         @(posedge i_clk); #1;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      if (!err && we)
         for (int i = 0; i < n; i++) ref_b[8'(addr + 32'(i))] = wd[8*i +: 8];
   endtask

   int rsp0;

   initial begin
      i_reset_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0;
      i_funct3 = '0; i_addr = '0; i_wdata = '0;
      for (int a = 0; a < 256; a++) ref_b[a] = init_byte(8'(a));
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_ready", 32'(o_req_ready), 32'd1);
      chk("rst_rspv",  32'(o_rsp_valid), 32'd0);
      chk("rst_wren",  32'(o_mem_wren),  32'd0);
      chk("rst_maddr", o_mem_addr, 32'd0);
      chk("rst_rdata", o_rdata,    32'd0);
      mem_init = 1'b0;
      i_reset_n = 1'b1;
      @(posedge i_clk); #1;
      chk_en = 1'b1;

      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      chk("sw_lat", 32'(lat), 32'd2);
      chk("sw_err", 32'(last_err), 32'd0);
      chk("sw_nbeat", 32'(wb_n), 32'd1);
      chk("sw_addr", wb_addr[0], 32'h10);
      chk("sw_mask", 32'(wb_mask[0]), 32'hF);
      chk("sw_data", wb_data[0], 32'hDEADBEEF);

      do_req(1'b1, 3'b000, 32'h13, 32'h000000AB);
      chk("sb_addr", wb_addr[0], 32'h10);
      chk("sb_mask", 32'(wb_mask[0]), 32'h8);
      chk("sb_data", wb_data[0], 32'hAB000000);
      do_req(1'b0, 3'b000, 32'h13, 32'h0);
      chk("lb_rdata", last_rdata, 32'hFFFFFFAB);
      do_req(1'b0, 3'b100, 32'h13, 32'h0);
      chk("lbu_rdata", last_rdata, 32'h000000AB);
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      chk("lw_rdata", last_rdata, 32'hABADBEEF);

      do_req(1'b0, 3'b001, 32'h22, 32'h0);
      chk("lh_rdata", last_rdata, 32'hFFFF8001);
      do_req(1'b0, 3'b101, 32'h22, 32'h0);
      chk("lhu_rdata", last_rdata, 32'h00008001);

      do_req(1'b1, 3'b010, 32'h41, 32'h11223344);
`ifdef LSU_MISALIGN_SPLIT_EN
      chk("sw41_lat", 32'(lat), 32'd3);
      chk("sw41_err", 32'(last_err), 32'd0);
      chk("sw41_nbeat", 32'(wb_n), 32'd2);
      chk("sw41_a0", wb_addr[0], 32'h40);
      chk("sw41_m0", 32'(wb_mask[0]), 32'hE);
      chk("sw41_d0", wb_data[0], 32'h22334400);
      chk("sw41_a1", wb_addr[1], 32'h44);
      chk("sw41_m1", 32'(wb_mask[1]), 32'h1);
      chk("sw41_d1", wb_data[1], 32'h00000011);
      do_req(1'b0, 3'b010, 32'h41, 32'h0);
      chk("lw41_rdata", last_rdata, 32'h11223344);
`else
      chk("sw41_lat", 32'(lat), 32'd1);
      chk("sw41_err", 32'(last_err), 32'd1);
      chk("sw41_nbeat", 32'(wb_n), 32'd0);
`endif

      do_req(1'b0, 3'b011, 32'h10, 32'h0);
      chk("f011_err", 32'(last_err), 32'd1);
      chk("f011_rdata", last_rdata, 32'd0);
      chk("f011_lat", 32'(lat), 32'd1);
      do_req(1'b1, 3'b100, 32'h14, 32'h55);
      chk("sbu_err", 32'(last_err), 32'd1);
      chk("sbu_nbeat", 32'(wb_n), 32'd0);

      do_req(1'b0, 3'b001, 32'h21, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
      chk("lh21_rdata", last_rdata, 32'h0000017F);
      chk("lh21_lat", 32'(lat), 32'd2);
`else
      chk("lh21_err", 32'(last_err), 32'd1);
`endif
      do_req(1'b1, 3'b001, 32'h23, 32'h0000BEEF);
      do_req(1'b0, 3'b101, 32'h23, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
      chk("lhu23_rdata", last_rdata, 32'h0000BEEF);
      chk("lhu23_lat", 32'(lat), 32'd3);
`endif
      do_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_SPLIT_EN
      chk("wrap_a0", wb_addr[0], 32'hFFFFFFFC);
      chk("wrap_m0", 32'(wb_mask[0]), 32'hC);
      chk("wrap_a1", wb_addr[1], 32'h00000000);
      chk("wrap_m1", 32'(wb_mask[1]), 32'h3);
`endif
      do_req(1'b0, 3'b010, 32'h0, 32'h0);

      // Reset while the first store beat is on the bus.
      chk_en = 1'b0;
      exp_q.delete();
      i_req_valid = 1'b1; i_req_we = 1'b1; i_funct3 = 3'b010;
      i_addr = 32'h50; i_wdata = 32'h12345678;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      chk("racc_wren", 32'(o_mem_wren), 32'd1);
      #2 i_reset_n = 1'b0;
      #1;
      chk("rmid_wren",  32'(o_mem_wren),  32'd0);
      chk("rmid_bmask", 32'(o_mem_bmask), 32'd0);
      chk("rmid_maddr", o_mem_addr, 32'd0);
      chk("rmid_rspv",  32'(o_rsp_valid), 32'd0);
      chk("rmid_ready", 32'(o_req_ready), 32'd1);
      rsp0 = rsp_cnt;
      repeat (2) @(posedge i_clk);
      #1 i_reset_n = 1'b1;
      repeat (4) @(posedge i_clk);
      #1;
      chk("rrel_ready", 32'(o_req_ready), 32'd1);
      chk("rrel_norsp", 32'(rsp_cnt - rsp0), 32'd0);
      chk_en = 1'b1;
      do_req(1'b0, 3'b010, 32'h50, 32'h0);
      chk("rrel_nowrite", last_rdata, init_word(20));

      repeat (2) @(posedge i_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
